// File: rtl/alu_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_arb_pkg                                                  |
// | Purpose : Shared types and helpers for the ALU request arbiter.        |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
package alu_arb_pkg;

   localparam int FLAG_W     = 6;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_CMD_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic err;
      logic oflow;
      logic cout;
      logic g;
      logic l;
      logic e;
   } alu_flags_t;

   // Request bundle as seen at the default operand/command widths.
   typedef struct packed {
      logic                  mode;
      logic                  cin;
      logic [DEF_CMD_W-1:0]  cmd;
      logic [1:0]            inp_valid;
      logic [DEF_DATA_W-1:0] opa;
      logic [DEF_DATA_W-1:0] opb;
   } alu_req_t;

   // Round-robin position 'step' places after 'base', wrapped into 0..n-1.
   function automatic int rr_wrap(input int base, input int step, input int n);
      return (base + step) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_req_arbiter_if                                           |
// | Purpose : Requester, ALU and response bundle of the ALU arbiter.       |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface alu_req_arbiter_if #(
   parameter int N_REQ        = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int CMD_WIDTH    = 4,
   parameter int RESULT_WIDTH = 2*DATA_WIDTH
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0]            req_mode;
   logic [N_REQ-1:0]            req_cin;
   logic [N_REQ*CMD_WIDTH-1:0]  req_cmd;
   logic [N_REQ*2-1:0]          req_inp_valid;
   logic [N_REQ*DATA_WIDTH-1:0] req_opa;
   logic [N_REQ*DATA_WIDTH-1:0] req_opb;

   logic                        alu_ce;
   logic                        alu_mode;
   logic                        alu_cin;
   logic [CMD_WIDTH-1:0]        alu_cmd;
   logic [1:0]                  alu_inp_valid;
   logic [DATA_WIDTH-1:0]       alu_opa;
   logic [DATA_WIDTH-1:0]       alu_opb;
   logic [RESULT_WIDTH-1:0]     alu_res;
   logic [5:0]                  alu_flags;

   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [IDX_W-1:0]            rsp_id;
   logic [RESULT_WIDTH-1:0]     rsp_res;
   logic [5:0]                  rsp_flags;

   // Arbiter side.
   modport slave (
      input  req_valid, req_mode, req_cin, req_cmd, req_inp_valid, req_opa, req_opb,
      output req_ready,
      output alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
      input  alu_res, alu_flags,
      output rsp_valid, rsp_id, rsp_res, rsp_flags,
      input  rsp_ready
   );

   // Requesters, ALU and response consumer side.
   modport master (
      output req_valid, req_mode, req_cin, req_cmd, req_inp_valid, req_opa, req_opb,
      input  req_ready,
      input  alu_ce, alu_mode, alu_cin, alu_cmd, alu_inp_valid, alu_opa, alu_opb,
      output alu_res, alu_flags,
      input  rsp_valid, rsp_id, rsp_res, rsp_flags,
      output rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_rr_arbiter                                               |
// | Purpose : Combinational round-robin pick, searching upward from ptr+1. |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module alu_rr_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  wire logic [N_REQ-1:0] req_i,
   input  wire logic [IDX_W-1:0] ptr_i,
   output logic      [N_REQ-1:0] grant_o,
   output logic      [IDX_W-1:0] idx_o,
   output logic                  any_o
);

   // First requester after the pointer wins; the pointer itself is checked last.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      found   = 1'b0;
      cand    = '0;
      grant_o = '0;
      idx_o   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'(rr_wrap(int'(ptr_i), k, N_REQ));
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            grant_o[cand]  = 1'b1;
            idx_o          = cand;
         end
      end
      any_o = found;
   end

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : alu_req_arbiter                                              |
// | Purpose : Shares one ALU between N_REQ requesters, one op at a time,   |
// |           returning result/flags over a valid/ready response.          |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int CMD_WIDTH    = 4,
   parameter int RESULT_WIDTH = 2*DATA_WIDTH,
   parameter int ALU_LATENCY  = 1
) (
   input wire logic        clk,
   input wire logic        rst,
   alu_req_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = 3;

   arb_state_e              state_q;
   logic [IDX_W-1:0]        ptr_q;
   logic [IDX_W-1:0]        id_q;
   logic [CNT_W-1:0]        cnt_q;

   logic                    alu_ce_q;
   logic                    mode_q;
   logic                    cin_q;
   logic [CMD_WIDTH-1:0]    cmd_q;
   logic [1:0]              inpv_q;
   logic [DATA_WIDTH-1:0]   opa_q;
   logic [DATA_WIDTH-1:0]   opb_q;

   logic                    rsp_valid_q;
   logic [IDX_W-1:0]        rsp_id_q;
   logic [RESULT_WIDTH-1:0] rsp_res_q;
   alu_flags_t              rsp_flags_q;

   logic [N_REQ-1:0]        grant_w;
   logic [IDX_W-1:0]        gidx_w;
   logic                    gany_w;

   alu_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant_w),
      .idx_o   (gidx_w),
      .any_o   (gany_w)
   );

   // Grant is only offered while idle and out of reset.
   assign bus.req_ready = (state_q == IDLE && !rst) ? grant_w : '0;

   assign bus.alu_ce        = alu_ce_q;
   assign bus.alu_mode      = mode_q;
   assign bus.alu_cin       = cin_q;
   assign bus.alu_cmd       = cmd_q;
   assign bus.alu_inp_valid = inpv_q;
   assign bus.alu_opa       = opa_q;
   assign bus.alu_opb       = opb_q;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_flags = rsp_flags_q;

   // Grant / hold operands for the ALU latency / return the captured response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= IDX_W'(N_REQ - 1);
         id_q        <= '0;
         cnt_q       <= '0;
         alu_ce_q    <= 1'b0;
         mode_q      <= 1'b0;
         cin_q       <= 1'b0;
         cmd_q       <= '0;
         inpv_q      <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_res_q   <= '0;
         rsp_flags_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gany_w) begin
                  mode_q   <= bus.req_mode[gidx_w];
                  cin_q    <= bus.req_cin[gidx_w];
                  cmd_q    <= CMD_WIDTH'(bus.req_cmd >> (gidx_w * CMD_WIDTH));
                  inpv_q   <= 2'(bus.req_inp_valid >> (gidx_w * 2));
                  opa_q    <= DATA_WIDTH'(bus.req_opa >> (gidx_w * DATA_WIDTH));
                  opb_q    <= DATA_WIDTH'(bus.req_opb >> (gidx_w * DATA_WIDTH));
                  ptr_q    <= gidx_w;
                  id_q     <= gidx_w;
                  cnt_q    <= CNT_W'(ALU_LATENCY);
                  alu_ce_q <= 1'b1;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == '0) begin
                  rsp_res_q   <= bus.alu_res;
                  rsp_flags_q <= alu_flags_t'(bus.alu_flags);
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  alu_ce_q    <= 1'b0;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_alu_req_arbiter                                           |
// | Purpose : Directed + random stimulus against a timeline-based model.   |
// | Rev     : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_alu_req_arbiter;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int CW   = 4;
   localparam int RW   = 16;
   localparam int L    = 1;
   localparam int IW   = 2;
   localparam int NCYC = 3000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_req_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .RESULT_WIDTH(RW)) bus ();

   alu_req_arbiter #(
      .N_REQ(N), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .RESULT_WIDTH(RW), .ALU_LATENCY(L)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   // Model: an operation is described by its grant cycle; everything else follows from time.
   bit            m_have_op;
   int            m_gc;
   int            m_last;
   logic          m_mode, m_cin;
   logic [CW-1:0] m_cmd;
   logic [1:0]    m_inpv;
   logic [DW-1:0] m_opa, m_opb;
   logic [IW-1:0] m_rsp_id;
   logic [RW-1:0] m_rsp_res;
   logic [5:0]    m_rsp_flags;

   logic [RW-1:0] res5;
   logic [RW-1:0] held_res;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int from);
      logic [N-1:0] r;
      for (int k = 1; k <= N; k++) begin
         r = v >> ((from + k) % N);
         if (r[0]) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_have_op = 1'b0; m_gc = 0; m_last = N - 1;
      m_mode = 1'b0; m_cin = 1'b0; m_cmd = '0; m_inpv = '0; m_opa = '0; m_opb = '0;
      m_rsp_id = '0; m_rsp_res = '0; m_rsp_flags = '0;
   endtask

   task automatic drive();
      bus.alu_res       = RW'($urandom);
      bus.alu_flags     = 6'($urandom);
      bus.req_mode      = N'($urandom);
      bus.req_cin       = N'($urandom);
      bus.req_cmd       = (N*CW)'($urandom);
      bus.req_inp_valid = (N*2)'($urandom);
      bus.req_opa       = (N*DW)'($urandom);
      bus.req_opb       = (N*DW)'($urandom);
      bus.req_valid     = '0;
      bus.rsp_ready     = 1'b1;
      rst = (cyc <= 2) || (cyc == 8) || (cyc == 40);
      if (cyc == 3) begin
         bus.req_valid          = 4'b0100;
         bus.req_cmd[8 +: 4]    = 4'h0;
         bus.req_mode[2]        = 1'b1;
         bus.req_cin[2]         = 1'b0;
         bus.req_inp_valid[4 +: 2] = 2'b11;
         bus.req_opa[16 +: 8]   = 8'h05;
         bus.req_opb[16 +: 8]   = 8'h03;
      end
      if (cyc >= 9 && cyc <= 28) bus.req_valid = 4'b1111;
      if (cyc == 29) bus.req_valid = 4'b0010;
      if (cyc >= 30 && cyc <= 37) bus.req_valid = 4'b1111;
      if (cyc >= 32 && cyc <= 36) bus.rsp_ready = 1'b0;
      if (cyc == 38) bus.req_valid = 4'b1000;
      if (cyc == 41) begin
         bus.req_valid     = 4'b1001;
         bus.req_inp_valid = '0;
      end
      if (cyc == 43) bus.alu_flags = 6'b100000;
      if (cyc >= 45) begin
         bus.req_valid = N'($urandom);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (cyc >= 50) rst = ($urandom_range(0, 63) == 0);
   endtask

   task automatic compare_model();
      logic [N-1:0] e_rr;
      bit           busy, rv;
      int           p;
      busy = m_have_op && (cyc >= m_gc + 1) && (cyc <= m_gc + 1 + L);
      rv   = m_have_op && (cyc >= m_gc + 2 + L);
      e_rr = '0;
      if (!rst && !m_have_op) begin
         p = pick(bus.req_valid, m_last);
         if (p >= 0) e_rr = N'(1) << p;
      end
      chk("req_ready",     64'(bus.req_ready),     64'(e_rr));
      chk("alu_ce",        64'(bus.alu_ce),        64'(busy));
      chk("alu_mode",      64'(bus.alu_mode),      64'(m_mode));
      chk("alu_cin",       64'(bus.alu_cin),       64'(m_cin));
      chk("alu_cmd",       64'(bus.alu_cmd),       64'(m_cmd));
      chk("alu_inp_valid", 64'(bus.alu_inp_valid), 64'(m_inpv));
      chk("alu_opa",       64'(bus.alu_opa),       64'(m_opa));
      chk("alu_opb",       64'(bus.alu_opb),       64'(m_opb));
      chk("rsp_valid",     64'(bus.rsp_valid),     64'(rv));
      chk("rsp_id",        64'(bus.rsp_id),        64'(m_rsp_id));
      chk("rsp_res",       64'(bus.rsp_res),       64'(m_rsp_res));
      chk("rsp_flags",     64'(bus.rsp_flags),     64'(m_rsp_flags));
   endtask

   task automatic model_step();
      int g;
      if (rst) begin
         model_reset();
      end else if (!m_have_op) begin
         g = pick(bus.req_valid, m_last);
         if (g >= 0) begin
            m_have_op = 1'b1; m_gc = cyc; m_last = g;
            m_mode = bus.req_mode[g];
            m_cin  = bus.req_cin[g];
            m_cmd  = CW'(bus.req_cmd >> (g * CW));
            m_inpv = 2'(bus.req_inp_valid >> (g * 2));
            m_opa  = DW'(bus.req_opa >> (g * DW));
            m_opb  = DW'(bus.req_opb >> (g * DW));
         end
      end else if (cyc == m_gc + 1 + L) begin
         m_rsp_res   = bus.alu_res;
         m_rsp_flags = bus.alu_flags;
         m_rsp_id    = IW'(m_last);
      end else if (cyc >= m_gc + 2 + L && bus.rsp_ready) begin
         m_have_op = 1'b0;
      end
   endtask

   // Hand-derived expectations for the directed opening sequence.
   task automatic literal_checks();
      case (cyc)
         1: begin
            chk("rst_alu_ce",    64'(bus.alu_ce),    64'd0);
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
         end
         3:  chk("single_grant", 64'(bus.req_ready), 64'h4);
         4: begin
            chk("single_ce1", 64'(bus.alu_ce),   64'd1);
            chk("single_opa", 64'(bus.alu_opa),  64'h05);
            chk("single_opb", 64'(bus.alu_opb),  64'h03);
            chk("single_mode", 64'(bus.alu_mode), 64'd1);
         end
         5: begin
            chk("single_ce2", 64'(bus.alu_ce), 64'd1);
            res5 = bus.alu_res;
         end
         6: begin
            chk("single_rv",  64'(bus.rsp_valid), 64'd1);
            chk("single_id",  64'(bus.rsp_id),    64'd2);
            chk("single_res", 64'(bus.rsp_res),   64'(res5));
            chk("single_ce0", 64'(bus.alu_ce),    64'd0);
         end
         7:  chk("single_rv0", 64'(bus.rsp_valid), 64'd0);
         9:  chk("rr_g0", 64'(bus.req_ready), 64'h1);
         11: chk("rr_gap", 64'(bus.req_ready), 64'h0);
         13: chk("rr_g1", 64'(bus.req_ready), 64'h2);
         17: chk("rr_g2", 64'(bus.req_ready), 64'h4);
         21: chk("rr_g3", 64'(bus.req_ready), 64'h8);
         25: chk("rr_g0b", 64'(bus.req_ready), 64'h1);
         38: begin
            chk("bp_release", 64'(bus.rsp_valid), 64'd0);
            chk("ptr_grant3", 64'(bus.req_ready), 64'h8);
         end
         41: begin
            chk("rstmid_ce",    64'(bus.alu_ce),    64'd0);
            chk("rstmid_rv",    64'(bus.rsp_valid), 64'd0);
            chk("rstmid_grant", 64'(bus.req_ready), 64'h1);
         end
         42: chk("iv00_issue", 64'(bus.alu_inp_valid), 64'd0);
         44: begin
            chk("iv00_rv",  64'(bus.rsp_valid), 64'd1);
            chk("iv00_err", 64'(bus.rsp_flags), 64'h20);
            chk("iv00_id",  64'(bus.rsp_id),    64'd0);
         end
         default: ;
      endcase
      if (cyc == 32) held_res = bus.rsp_res;
      if (cyc >= 32 && cyc <= 37) begin
         chk("bp_rv",    64'(bus.rsp_valid), 64'd1);
         chk("bp_ready", 64'(bus.req_ready), 64'd0);
         chk("bp_ce",    64'(bus.alu_ce),    64'd0);
         chk("bp_id",    64'(bus.rsp_id),    64'd1);
         chk("bp_res",   64'(bus.rsp_res),   64'(held_res));
      end
   endtask

   initial begin
      model_reset();
      res5     = '0;
      held_res = '0;
      drive();
      @(posedge clk); #1;
      for (int c = 0; c < NCYC; c++) begin
         cyc = c;
         drive();
         @(negedge clk);
         compare_model();
         literal_checks();
         model_step();
         @(posedge clk); #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU instance between N_REQ requesters, e.g. several stimulus or agent paths driving a single DUT datapath.
- Arbitrates round-robin and holds the winning request's operands on the ALU input ports for the ALU's fixed latency.
- Captures result and flags, then returns them to the winner through a valid/ready response channel.
- Only one operation is in flight at a time; no pipelining across requesters.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, operand width (opa/opb)
- CMD_WIDTH, 4, ALU command width
- RESULT_WIDTH, 2*DATA_WIDTH, ALU result width
- ALU_LATENCY, 1, cycles from first cycle operands are presented with ce=1 until res/flags are valid (0..7)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request pending
- req_ready  out  N_REQ  one-hot grant pulse; handshake when req_valid[i]&req_ready[i]
- req_mode  in  N_REQ  per-requester mode (1 arithmetic, 0 logical)
- req_cin  in  N_REQ  per-requester carry-in
- req_cmd  in  N_REQ*CMD_WIDTH  packed commands, requester i at [i*CMD_WIDTH +: CMD_WIDTH]
- req_inp_valid  in  N_REQ*2  packed operand-valid pairs
- req_opa, req_opb  in  N_REQ*DATA_WIDTH each  packed operands
- alu_ce, alu_mode, alu_cin  out  1 each  to ALU
- alu_cmd  out  CMD_WIDTH  to ALU
- alu_inp_valid  out  2  to ALU
- alu_opa, alu_opb  out  DATA_WIDTH  to ALU
- alu_res  in  RESULT_WIDTH  from ALU
- alu_flags  in  6  {err,oflow,cout,g,l,e} from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(N_REQ)  index of requester owning the response
- rsp_res  out  RESULT_WIDTH  captured result
- rsp_flags  out  6  captured {err,oflow,cout,g,l,e}

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; all outputs 0, including req_ready and rsp_*.
  - Round-robin pointer=N_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation abandons the op; no response is produced; alu_ce drops the next cycle.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid, grant the first set bit searching upward from pointer+1 (wrapping).
  - Assert req_ready[g] combinationally this cycle only.
  - Latch that requester's mode/cin/cmd/inp_valid/opa/opb; pointer<=g; id<=g; cnt<=ALU_LATENCY; ->BUSY.
  - No req_valid: stay in IDLE, alu_ce=0.
- BUSY:
  - alu_ce=1; latched fields drive alu_* unchanged every cycle.
  - cnt decrements each cycle. When cnt==0: capture alu_res/alu_flags into rsp_res/rsp_flags, rsp_id<=id, ->RESP.
  - BUSY lasts exactly ALU_LATENCY+1 cycles.
- RESP:
  - alu_ce=0; rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready.
  - On handshake ->IDLE, rsp_valid=0 next cycle.
  - No new grant is issued in the same cycle as the response handshake.
- Latency: grant at cycle T, BUSY T+1..T+1+L, rsp_valid first high at T+2+L. Minimum issue interval is L+3 cycles.
- alu_* outputs in IDLE/RESP: alu_ce=0, other fields retain the last latched values (no glitching to 0).
- Fairness: a continuously requesting requester is granted within N_REQ grants.
- Requesters may deassert req_valid before grant; no handshake occurs. Requester inputs are ignored outside IDLE.
- Ops with inp_valid=2'b00 or an illegal cmd are still issued; the ALU's err flag is returned verbatim.
- All widths pass through unmodified; the block performs no arithmetic other than cnt and pointer wrap (pointer mod N_REQ).

Decomposition:
- Package alu_arb_pkg:
  - state enum {IDLE,BUSY,RESP}
  - alu_flags_t packed struct {err,oflow,cout,g,l,e}
  - alu_req_t packed struct {mode,cin,cmd,inp_valid,opa,opb}
  - FLAG_W=6
- Sub-module alu_rr_arbiter:
  - combinational round-robin grant from req vector + pointer, producing one-hot grant and binary index.

Test Plan:
- Single request: req_valid=4'b0100, cmd=0, mode=1, opa=8'h05, opb=8'h03, L=1 -> req_ready=4'b0100 at T; alu_ce=1 for T+1..T+2; rsp_valid at T+3 with rsp_id=2 and rsp_res=ALU model value.
- All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0; consecutive grants spaced exactly L+3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_res/rsp_id stable, no new req_ready pulse, alu_ce=0; handshake on cycle 6 -> IDLE next cycle.
- Reset asserted in second BUSY cycle (L=3) -> next cycle alu_ce=0, rsp_valid=0; pointer reset so a subsequent request on 4'b1001 grants requester 0.
- inp_valid=2'b00 request -> issued normally; rsp_flags.err mirrors ALU err=1.
- ALU_LATENCY=0 build -> BUSY is one cycle; rsp_valid at T+2; captured res matches alu_res sampled in that BUSY cycle.
